tone_share_arbiter: RTL and testbench



---
 rtl/piano_pkg.sv | 20 ++
 rtl/beat_timer.sv | 60 ++++++
 rtl/tone_share_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_tone_share_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared definitions for the piano tone path: arbiter state encoding, tone
// index width and the keypad-to-tone mapping.
package piano_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam int TONE_W = 5;
  localparam logic [TONE_W-1:0] TONE_REST    = 5'd0;
  localparam logic [TONE_W-1:0] KEY_TONE_OFS = 5'd1;

  // Keypad keys 0..15 map onto tones 1..16 so that tone 0 stays silence.
  function automatic logic [TONE_W-1:0] key_to_tone(input logic [3:0] code);
    return {1'b0, code} + KEY_TONE_OFS;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Note duration timer: a BEAT_DIV cycle divider feeding a beat counter.
// load restarts both counters and latches the length (0 counts as 1 beat).
module beat_timer #(
  parameter int BEAT_DIV = 6250000,
  parameter int LEN_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [LEN_W-1:0] len,
  output logic             done
);

  localparam int CYC_W = $clog2(BEAT_DIV);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             cyc_last_s;

  assign cyc_last_s = (cyc_q == CYC_W'(BEAT_DIV - 1));
  // done marks the last cycle of the programmed duration
  assign done = run && cyc_last_s && (beat_q == (len_q - LEN_W'(1)));

  // Next-state for divider, beat counter and latched length.
  always_comb begin
    cyc_d  = cyc_q;
    beat_d = beat_q;
    len_d  = len_q;
    if (load) begin
      cyc_d  = '0;
      beat_d = '0;
      len_d  = (len == '0) ? LEN_W'(1) : len;
    end else if (run) begin
      if (cyc_last_s) begin
        cyc_d  = '0;
        beat_d = beat_q + LEN_W'(1);
      end else begin
        cyc_d = cyc_q + CYC_W'(1);
      end
    end else begin
      cyc_d = cyc_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      beat_q <= '0;
      len_q  <= '0;
    end else begin
      cyc_q  <= cyc_d;
      beat_q <= beat_d;
      len_q  <= len_d;
    end
  end

endmodule

// File: rtl/tone_share_arbiter.sv
// Shares the single tone generator between keypad events and the auto-play
// reader. Define ARB_PREEMPT_EN to let keys cut auto notes short.
module tone_share_arbiter
  import piano_pkg::*;
#(
  parameter int BEAT_DIV   = 6250000,
  parameter int GAP_CYCLES = 250000,
  parameter int MAN_BEATS  = 2,
  parameter int LEN_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_rdy,
  input  logic [3:0]        key_code,
  input  logic              auto_req,
  input  logic [TONE_W-1:0] auto_note,
  input  logic [LEN_W-1:0]  auto_len,
  output logic              auto_ack,
  output logic              auto_abort,
  output logic [TONE_W-1:0] tone_idx,
  output logic              tone_en,
  output logic              src_auto,
  output logic              busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_e        state_q, state_d;
  logic [TONE_W-1:0] tone_idx_q, tone_idx_d;
  logic              tone_en_q, tone_en_d;
  logic              src_auto_q, src_auto_d;
  logic              busy_q, busy_d;
  logic              auto_ack_q, auto_ack_d;
  logic              auto_abort_q, auto_abort_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
`ifndef ARB_PREEMPT_EN
  logic              pend_vld_q, pend_vld_d;
  logic [3:0]        pend_code_q, pend_code_d;
`endif

  logic             man_grant_s;
  logic [3:0]       man_code_s;
  logic             auto_grant_s;
  logic             timer_load_s;
  logic [LEN_W-1:0] timer_len_s;
  logic             timer_done_s;
  logic             gap_last_s;

  beat_timer #(
    .BEAT_DIV (BEAT_DIV),
    .LEN_W    (LEN_W)
  ) u_beat_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load_s),
    .run   (state_q == PLAY),
    .len   (timer_len_s),
    .done  (timer_done_s)
  );

  assign gap_last_s = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));

  // Arbitration, state sequencing and next output values.
  always_comb begin
    state_d      = state_q;
    tone_idx_d   = tone_idx_q;
    src_auto_d   = src_auto_q;
    gap_cnt_d    = gap_cnt_q;
    auto_ack_d   = 1'b0;
    auto_abort_d = 1'b0;
    man_grant_s  = 1'b0;
    man_code_s   = key_code;
    auto_grant_s = 1'b0;
    timer_load_s = 1'b0;
    timer_len_s  = auto_len;
`ifndef ARB_PREEMPT_EN
    pend_vld_d   = pend_vld_q;
    pend_code_d  = pend_code_q;
`endif

    case (state_q)
      IDLE: begin
        if (key_rdy) begin
          man_grant_s = 1'b1;
        end else if (auto_req) begin
          auto_grant_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      PLAY: begin
`ifdef ARB_PREEMPT_EN
        if (key_rdy) begin
          man_grant_s  = 1'b1;
          auto_abort_d = src_auto_q;
        end else if (timer_done_s) begin
          state_d    = GAP;
          gap_cnt_d  = '0;
          tone_idx_d = TONE_REST;
        end else begin
          state_d = PLAY;
        end
`else
        // A key during an auto note waits; the newest key wins the slot.
        if (key_rdy && src_auto_q) begin
          pend_vld_d  = 1'b1;
          pend_code_d = key_code;
        end else begin
          pend_vld_d = pend_vld_q;
        end
        if (key_rdy && !src_auto_q) begin
          man_grant_s = 1'b1;
        end else if (timer_done_s) begin
          state_d    = GAP;
          gap_cnt_d  = '0;
          tone_idx_d = TONE_REST;
        end else begin
          state_d = PLAY;
        end
`endif
      end
      GAP: begin
        if (key_rdy) begin
          man_grant_s = 1'b1;
        end else if (gap_last_s) begin
`ifndef ARB_PREEMPT_EN
          if (pend_vld_q) begin
            man_grant_s = 1'b1;
            man_code_s  = pend_code_q;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (man_grant_s) begin
      state_d      = PLAY;
      tone_idx_d   = key_to_tone(man_code_s);
      src_auto_d   = 1'b0;
      timer_load_s = 1'b1;
      timer_len_s  = LEN_W'(MAN_BEATS);
`ifndef ARB_PREEMPT_EN
      pend_vld_d   = 1'b0;
`endif
    end else if (auto_grant_s) begin
      state_d      = PLAY;
      tone_idx_d   = auto_note;
      src_auto_d   = 1'b1;
      timer_load_s = 1'b1;
      timer_len_s  = auto_len;
      auto_ack_d   = 1'b1;
    end else begin
      timer_load_s = 1'b0;
    end

    tone_en_d = (state_d == PLAY) && (tone_idx_d != TONE_REST);
    busy_d    = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tone_idx_q   <= TONE_REST;
      tone_en_q    <= 1'b0;
      src_auto_q   <= 1'b0;
      busy_q       <= 1'b0;
      auto_ack_q   <= 1'b0;
      auto_abort_q <= 1'b0;
      gap_cnt_q    <= '0;
`ifndef ARB_PREEMPT_EN
      pend_vld_q   <= 1'b0;
      pend_code_q  <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      tone_idx_q   <= tone_idx_d;
      tone_en_q    <= tone_en_d;
      src_auto_q   <= src_auto_d;
      busy_q       <= busy_d;
      auto_ack_q   <= auto_ack_d;
      auto_abort_q <= auto_abort_d;
      gap_cnt_q    <= gap_cnt_d;
`ifndef ARB_PREEMPT_EN
      pend_vld_q   <= pend_vld_d;
      pend_code_q  <= pend_code_d;
`endif
    end
  end

  assign tone_idx   = tone_idx_q;
  assign tone_en    = tone_en_q;
  assign src_auto   = src_auto_q;
  assign busy       = busy_q;
  assign auto_ack   = auto_ack_q;
  assign auto_abort = auto_abort_q;

endmodule

// File: tb/tb_tone_share_arbiter.sv
// Self-checking bench for tone_share_arbiter: a cycle-level note/gap model
// checked every cycle, plus directed scenarios with hand-computed values.
module tb_tone_share_arbiter;

  localparam int BD = 4;
  localparam int GP = 2;
  localparam int MB = 2;
  localparam int LW = 4;
`ifdef ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_rdy = 1'b0;
  logic [3:0]    key_code = 4'd0;
  logic          auto_req = 1'b0;
  logic [4:0]    auto_note = 5'd0;
  logic [LW-1:0] auto_len = 4'd0;
  logic          auto_ack, auto_abort, tone_en, src_auto, busy;
  logic [4:0]    tone_idx;

  int  n_chk  = 0;
  int  n_pass = 0;
  bit  cmp_en = 1'b0;

  tone_share_arbiter #(
    .BEAT_DIV(BD), .GAP_CYCLES(GP), .MAN_BEATS(MB), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_rdy(key_rdy), .key_code(key_code),
    .auto_req(auto_req), .auto_note(auto_note), .auto_len(auto_len),
    .auto_ack(auto_ack), .auto_abort(auto_abort), .tone_idx(tone_idx),
    .tone_en(tone_en), .src_auto(src_auto), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: cycles of sound left, cycles of silence left, the note, its source.
  typedef struct {
    int       rem;
    int       gap;
    bit [4:0] note;
    bit       is_auto;
    bit       ack;
    bit       abort;
    bit       pvld;
    bit [3:0] pcode;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(mdl_t o, bit kr, bit [3:0] kc, bit ar,
                                bit [4:0] an, bit [LW-1:0] al);
    mdl_t n;
    bit playing, gapping, idle, take_key;
    n = o;
    n.ack = 1'b0;
    n.abort = 1'b0;
    playing = (o.rem > 0);
    gapping = !playing && (o.gap > 0);
    idle    = !playing && !gapping;
    take_key = kr && (idle || gapping || (playing && (!o.is_auto || PREEMPT)));
    if (take_key || (gapping && o.gap == 1 && o.pvld)) begin
      n.abort   = take_key && playing && o.is_auto;
      n.note    = take_key ? 5'(kc) + 5'd1 : 5'(o.pcode) + 5'd1;
      n.rem     = MB * BD;
      n.gap     = 0;
      n.is_auto = 1'b0;
      n.pvld    = 1'b0;
    end else if (idle && ar) begin
      n.note    = an;
      n.rem     = ((al == 0) ? 1 : int'(al)) * BD;
      n.is_auto = 1'b1;
      n.ack     = 1'b1;
    end else begin
      if (kr) begin
        n.pvld  = 1'b1;
        n.pcode = kc;
      end
      if (playing) begin
        n.rem = o.rem - 1;
        if (o.rem == 1) n.gap = GP;
      end else if (gapping) begin
        n.gap = o.gap - 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= step(m, key_rdy, key_code, auto_req, auto_note, auto_len);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_tone_idx", tone_idx, (m.rem > 0) ? int'(m.note) : 0);
      check("m_tone_en", tone_en, int'((m.rem > 0) && (m.note != 5'd0)));
      check("m_src_auto", src_auto, m.is_auto);
      check("m_busy", busy, int'((m.rem > 0) || (m.gap > 0)));
      check("m_auto_ack", auto_ack, m.ack);
      check("m_auto_abort", auto_abort, m.abort);
    end
  end

  task automatic step1();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_key(input logic [3:0] c);
    key_code = c;
    key_rdy  = 1'b1;
    step1();
    key_rdy  = 1'b0;
  endtask

  task automatic count_win(input int n, input logic [4:0] idx, output int en_n,
                           output int gap_n, output int idx_n, output int ack_n);
    en_n = 0; gap_n = 0; idx_n = 0; ack_n = 0;
    for (int i = 0; i < n; i++) begin
      if (tone_en) en_n++;
      if (busy && !tone_en) gap_n++;
      if (tone_en && tone_idx == idx) idx_n++;
      if (auto_ack) ack_n++;
      step1();
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      step1();
      k++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic start_auto(input logic [4:0] note, input logic [LW-1:0] len,
                            output int lat);
    auto_note = note;
    auto_len  = len;
    auto_req  = 1'b1;
    step1();
    lat = 0;
    while (!auto_ack && lat < 50) begin
      step1();
      lat++;
    end
    check("ack_seen", auto_ack, 1);
    auto_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int en_n, gap_n, idx_n, ack_n, lat, n, ab;
    step1();
    step1();
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    check("rst_tone_idx", tone_idx, 0);
    check("rst_tone_en", tone_en, 0);
    check("rst_busy", busy, 0);
    check("rst_src_auto", src_auto, 0);

    // 1: asynchronous reset in the middle of a note
    pulse_key(4'd1);
    step1();
    step1();
    check("t1_playing", tone_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t1_async_tone_en", tone_en, 0);
    check("t1_async_tone_idx", tone_idx, 0);
    check("t1_async_busy", busy, 0);
    step1();
    rst_n = 1'b1;
    step1();
    check("t1_post_busy", busy, 0);
    check("t1_post_idx", tone_idx, 0);

    // 2: manual key 5 -> tone 6 for 8 cycles, 2 silent gap cycles, idle
    pulse_key(4'd5);
    check("t2_idx", tone_idx, 6);
    count_win(11, 5'd6, en_n, gap_n, idx_n, ack_n);
    check("t2_en_cycles", en_n, 8);
    check("t2_idx_cycles", idx_n, 8);
    check("t2_gap_cycles", gap_n, 2);
    check("t2_idle", busy, 0);

    // 3: auto note 9 with len 0 plays one beat; rest note stays silent
    start_auto(5'd9, 4'd0, lat);
    check("t3_lat", lat, 0);
    check("t3_src", src_auto, 1);
    count_win(7, 5'd9, en_n, gap_n, idx_n, ack_n);
    check("t3_en_cycles", en_n, 4);
    check("t3_idx_cycles", idx_n, 4);
    check("t3_ack_pulses", ack_n, 1);
    wait_idle();
    start_auto(5'd0, 4'd2, lat);
    count_win(11, 5'd0, en_n, gap_n, idx_n, ack_n);
    check("t3_rest_en", en_n, 0);
    check("t3_rest_busy", gap_n, 10);
    check("t3_rest_ack", ack_n, 1);
    wait_idle();

    // 4: key and auto in the same idle cycle; auto grant 11 cycles later
    auto_note = 5'd7;
    auto_len  = 4'd1;
    auto_req  = 1'b1;
    key_code  = 4'd3;
    key_rdy   = 1'b1;
    step1();
    key_rdy   = 1'b0;
    check("t4_idx", tone_idx, 4);
    check("t4_src", src_auto, 0);
    check("t4_no_ack", auto_ack, 0);
    n = 0;
    while (!auto_ack && n < 40) begin
      step1();
      n++;
    end
    auto_req = 1'b0;
    check("t4_auto_delay", n, 11);
    check("t4_auto_idx", tone_idx, 7);
    check("t4_auto_src", src_auto, 1);
    wait_idle();

    // 5: key 15 arrives 3 cycles into a 3-beat auto note
    start_auto(5'd20, 4'd3, lat);
    step1();
    step1();
    step1();
    pulse_key(4'd15);
`ifdef ARB_PREEMPT_EN
    check("t5_abort", auto_abort, 1);
    check("t5_idx", tone_idx, 16);
    check("t5_src", src_auto, 0);
    step1();
    check("t5_abort_once", auto_abort, 0);
`else
    check("t5_no_abort", auto_abort, 0);
    check("t5_still_auto", tone_idx, 20);
    n = 0;
    ab = 0;
    while (tone_idx != 5'd16 && n < 40) begin
      if (auto_abort) ab++;
      step1();
      n++;
    end
    check("t5_pend_delay", n, 10);
    check("t5_abort_cnt", ab, 0);
    check("t5_pend_src", src_auto, 0);
`endif
    wait_idle();

    // 6: key 0 during a manual gap retriggers with the full duration
    pulse_key(4'd2);
    repeat (8) step1();
    check("t6_in_gap_en", tone_en, 0);
    check("t6_in_gap_busy", busy, 1);
    pulse_key(4'd0);
    check("t6_idx", tone_idx, 1);
    count_win(11, 5'd1, en_n, gap_n, idx_n, ack_n);
    check("t6_en_cycles", en_n, 8);
    check("t6_idx_cycles", idx_n, 8);
    check("t6_gap_cycles", gap_n, 2);
    wait_idle();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
